cmult_arbiter: RTL and testbench

CMULT_ARBITER -- requirements
Module: cmult_arbiter

---
 rtl/cmult_arbiter.sv | 149 ++++++++++++++
 tb/tb_cmult_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmult_arbiter.sv
// Two-requester arbiter in front of one shared complex multiplier, with result routing by requester id.
// Optional per-requester grant counters are enabled with `define CMULT_ARB_STATS_EN.
module cmult_arbiter #(
    parameter int NB_INPUT  = 17,
    parameter int NB_OUTPUT = 17,
    parameter int MULT_LAT  = 1,
    parameter int ARB_MODE  = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [1:0]                  i_valid,
    output logic [1:0]                  o_ready,
    input  logic signed [NB_INPUT-1:0]  i_real_A0,
    input  logic signed [NB_INPUT-1:0]  i_imag_A0,
    input  logic signed [NB_INPUT-1:0]  i_real_B0,
    input  logic signed [NB_INPUT-1:0]  i_imag_B0,
    input  logic signed [NB_INPUT-1:0]  i_real_A1,
    input  logic signed [NB_INPUT-1:0]  i_imag_A1,
    input  logic signed [NB_INPUT-1:0]  i_real_B1,
    input  logic signed [NB_INPUT-1:0]  i_imag_B1,
    output logic signed [NB_INPUT-1:0]  o_mult_real_A,
    output logic signed [NB_INPUT-1:0]  o_mult_imag_A,
    output logic signed [NB_INPUT-1:0]  o_mult_real_B,
    output logic signed [NB_INPUT-1:0]  o_mult_imag_B,
    input  logic signed [NB_OUTPUT-1:0] i_mult_real,
    input  logic signed [NB_OUTPUT-1:0] i_mult_imag,
    output logic signed [NB_OUTPUT-1:0] o_res_real,
    output logic signed [NB_OUTPUT-1:0] o_res_imag,
    output logic [1:0]                  o_res_valid
`ifdef CMULT_ARB_STATS_EN
    ,
    output logic [15:0]                 o_grant_cnt0,
    output logic [15:0]                 o_grant_cnt1
`endif
);

    // Pipeline depth kept inside the legal latency range so the shift registers stay well formed.
    localparam int unsigned PIPE_D = (MULT_LAT < 1) ? 1 : ((MULT_LAT > 4) ? 4 : MULT_LAT);

    typedef enum logic {
        PTR_REQ0 = 1'b0,
        PTR_REQ1 = 1'b1
    } ptr_e;

    ptr_e              ptr_q, ptr_d;
    logic [PIPE_D-1:0] vld_q, vld_d;
    logic [PIPE_D-1:0] id_q, id_d;
    logic [1:0]        gnt_c;
    logic              xfer_c;

    // Grant: single requester always wins; on conflict the pointer (or requester 0) decides.
    always_comb begin
        gnt_c = 2'b00;
        if (!i_rst) begin
            case (i_valid)
                2'b01:   gnt_c = 2'b01;
                2'b10:   gnt_c = 2'b10;
                2'b11:   gnt_c = (ARB_MODE == 1 || ptr_q == PTR_REQ0) ? 2'b01 : 2'b10;
                default: gnt_c = 2'b00;
            endcase
        end
    end

    assign o_ready = gnt_c;
    assign xfer_c  = |gnt_c;

    // Operand mux toward the shared multiplier; idle cycles present zeros.
    always_comb begin
        o_mult_real_A = '0;
        o_mult_imag_A = '0;
        o_mult_real_B = '0;
        o_mult_imag_B = '0;
        if (gnt_c[0]) begin
            o_mult_real_A = i_real_A0;
            o_mult_imag_A = i_imag_A0;
            o_mult_real_B = i_real_B0;
            o_mult_imag_B = i_imag_B0;
        end else if (gnt_c[1]) begin
            o_mult_real_A = i_real_A1;
            o_mult_imag_A = i_imag_A1;
            o_mult_real_B = i_real_B1;
            o_mult_imag_B = i_imag_B1;
        end
    end

    // Next state: pointer hands priority to the other requester; valid/id tags shift with the multiplier.
    always_comb begin
        ptr_d = ptr_q;
        vld_d = PIPE_D'({vld_q, xfer_c});
        id_d  = PIPE_D'({id_q, gnt_c[1]});
        if (ARB_MODE == 0 && xfer_c) begin
            ptr_d = gnt_c[1] ? PTR_REQ0 : PTR_REQ1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= PTR_REQ0;
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    // Result routing: the tag leaving the pipeline names the owner of the multiplier output.
    always_comb begin
        o_res_valid = 2'b00;
        if (!i_rst && vld_q[PIPE_D-1]) begin
            o_res_valid = id_q[PIPE_D-1] ? 2'b10 : 2'b01;
        end
    end

    assign o_res_real = i_mult_real;
    assign o_res_imag = i_mult_imag;

`ifdef CMULT_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Saturating per-requester transfer counters.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (gnt_c[0] && cnt0_q != 16'hFFFF) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (gnt_c[1] && cnt1_q != 16'hFFFF) begin
            cnt1_d = cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign o_grant_cnt0 = cnt0_q;
    assign o_grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_cmult_arbiter.sv
// Bench for cmult_arbiter: three instances (RR/lat1, fixed/lat2, RR/lat3) against a queue-style reference model.
module tb_cmult_arbiter;

    localparam int NI = 17;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst [3];
    logic [1:0]           vin [3];
    logic [1:0]           rdy [3];
    logic [1:0]           rv  [3];
    logic signed [NI-1:0] ra0, ia0, rb0, ib0, ra1, ia1, rb1, ib1;
    logic signed [NI-1:0] omra [3], omia [3], omrb [3], omib [3];
    logic signed [NI-1:0] resr [3], resi [3];
    logic signed [NI-1:0] hr [3][4];
    logic signed [NI-1:0] hi [3][4];
`ifdef CMULT_ARB_STATS_EN
    logic [15:0]          c0 [3], c1 [3];
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    function automatic int lat_of(input int n);
        return n + 1;
    endfunction

    function automatic bit mode_of(input int n);
        return (n == 1);
    endfunction

    // Complex product, truncated to result width.
    function automatic logic [2*NI-1:0] cmul(input logic signed [NI-1:0] ar, ai, br, bi);
        logic signed [2*NI-1:0] pr, pi;
        pr = (2*NI)'(ar) * (2*NI)'(br) - (2*NI)'(ai) * (2*NI)'(bi);
        pi = (2*NI)'(ar) * (2*NI)'(bi) + (2*NI)'(ai) * (2*NI)'(br);
        return {pr[NI-1:0], pi[NI-1:0]};
    endfunction

    task automatic chk(input string name, input logic signed [95:0] act, input logic signed [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cmult_arbiter #(
            .NB_INPUT (NI),
            .NB_OUTPUT(NI),
            .MULT_LAT (g + 1),
            .ARB_MODE (g == 1 ? 1 : 0)
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst[g]),
            .i_valid      (vin[g]),
            .o_ready      (rdy[g]),
            .i_real_A0    (ra0),
            .i_imag_A0    (ia0),
            .i_real_B0    (rb0),
            .i_imag_B0    (ib0),
            .i_real_A1    (ra1),
            .i_imag_A1    (ia1),
            .i_real_B1    (rb1),
            .i_imag_B1    (ib1),
            .o_mult_real_A(omra[g]),
            .o_mult_imag_A(omia[g]),
            .o_mult_real_B(omrb[g]),
            .o_mult_imag_B(omib[g]),
            .i_mult_real  (hr[g][g]),
            .i_mult_imag  (hi[g][g]),
            .o_res_real   (resr[g]),
            .o_res_imag   (resi[g]),
            .o_res_valid  (rv[g])
`ifdef CMULT_ARB_STATS_EN
            ,
            .o_grant_cnt0 (c0[g]),
            .o_grant_cnt1 (c1[g])
`endif
        );
    end

    // Shared multiplier model: product of the presented operands, delayed by each instance's latency.
    always @(posedge clk) begin
        logic [2*NI-1:0] p;
        for (int n = 0; n < 3; n++) begin
            p = cmul(omra[n], omia[n], omrb[n], omib[n]);
            hr[n][0] <= p[2*NI-1:NI];
            hi[n][0] <= p[NI-1:0];
            for (int k = 1; k < 4; k++) begin
                hr[n][k] <= hr[n][k-1];
                hi[n][k] <= hi[n][k-1];
            end
        end
    end

    // Reference model: grant rule, round-robin pointer and a due-slot table of pending results.
    bit                   mptr [3];
    bit                   sv   [3][8];
    bit                   sid  [3][8];
    logic signed [NI-1:0] sr   [3][8];
    logic signed [NI-1:0] si   [3][8];

    always @(negedge clk) begin
        logic [1:0]           er, erv;
        logic                 w;
        logic signed [NI-1:0] ea, eb, ec, ed;
        logic [2*NI-1:0]      p;
        int                   s, d;
        for (int n = 0; n < 3; n++) begin
            s  = cyc % 8;
            er = 2'b00; erv = 2'b00; w = 1'b0;
            ea = '0; eb = '0; ec = '0; ed = '0;
            if (rst[n]) begin
                for (int k = 0; k < 8; k++) sv[n][k] = 1'b0;
                mptr[n] = 1'b0;
            end else begin
                if (vin[n] == 2'b11) w = mode_of(n) ? 1'b0 : mptr[n];
                else                 w = (vin[n] == 2'b10);
                if (vin[n] != 2'b00) er = w ? 2'b10 : 2'b01;
                if (sv[n][s]) erv = sid[n][s] ? 2'b10 : 2'b01;
                if (er != 2'b00) begin
                    ea = w ? ra1 : ra0;
                    eb = w ? ia1 : ia0;
                    ec = w ? rb1 : rb0;
                    ed = w ? ib1 : ib0;
                end
            end
            chk($sformatf("ready[%0d]", n), rdy[n], er);
            chk($sformatf("res_valid[%0d]", n), rv[n], erv);
            chk($sformatf("mult_ops[%0d]", n), {omra[n], omia[n], omrb[n], omib[n]}, {ea, eb, ec, ed});
            if (erv != 2'b00)
                chk($sformatf("res[%0d]", n), {resr[n], resi[n]}, {sr[n][s], si[n][s]});
            sv[n][s] = 1'b0;
            if (er != 2'b00) begin
                d = (cyc + lat_of(n)) % 8;
                p = cmul(ea, eb, ec, ed);
                sv[n][d]  = 1'b1;
                sid[n][d] = w;
                sr[n][d]  = p[2*NI-1:NI];
                si[n][d]  = p[NI-1:0];
                if (!mode_of(n)) mptr[n] = ~w;
            end
        end
        cyc++;
    end

    task automatic rnd_ops();
        ra0 = NI'($urandom); ia0 = NI'($urandom); rb0 = NI'($urandom); ib0 = NI'($urandom);
        ra1 = NI'($urandom); ia1 = NI'($urandom); rb1 = NI'($urandom); ib1 = NI'($urandom);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int n = 0; n < 3; n++) begin
            rst[n] = 1'b1;
            vin[n] = 2'b00;
        end
        rnd_ops();
        repeat (3) @(posedge clk);
        #1;
        for (int n = 0; n < 3; n++) rst[n] = 1'b0;

        // Round-robin alternation under constant contention, results one cycle later.
        for (int i = 0; i < 7; i++) begin
            vin[0] = (i < 6) ? 2'b11 : 2'b00;
            @(negedge clk);
            chk("rr_ready", rdy[0], (i < 6) ? ((i % 2) ? 2'b10 : 2'b01) : 2'b00);
            chk("rr_res_valid", rv[0], (i == 0) ? 2'b00 : (((i - 1) % 2) ? 2'b10 : 2'b01));
            next_cycle();
        end

        // Lone requester 0 is granted every cycle.
        for (int i = 0; i < 6; i++) begin
            vin[0] = (i < 5) ? 2'b01 : 2'b00;
            @(negedge clk);
            chk("solo_ready", rdy[0], (i < 5) ? 2'b01 : 2'b00);
            chk("solo_res_valid", rv[0], (i >= 1) ? 2'b01 : 2'b00);
            next_cycle();
        end

        // Known product on requester 1: (3+4j)(1+2j) = -5+10j.
        ra1 = 17'sd3; ia1 = 17'sd4; rb1 = 17'sd1; ib1 = 17'sd2;
        vin[0] = 2'b10;
        @(negedge clk);
        chk("lit_ready", rdy[0], 2'b10);
        chk("lit_ra", omra[0], 3);
        chk("lit_ia", omia[0], 4);
        chk("lit_rb", omrb[0], 1);
        chk("lit_ib", omib[0], 2);
        next_cycle();
        vin[0] = 2'b00;
        @(negedge clk);
        chk("lit_res_valid", rv[0], 2'b10);
        chk("lit_res_real", resr[0], -5);
        chk("lit_res_imag", resi[0], 10);
        next_cycle();

        // Fixed priority: requester 0 wins every conflict.
        for (int i = 0; i < 4; i++) begin
            vin[1] = 2'b11;
            @(negedge clk);
            chk("fixed_ready", rdy[1], 2'b01);
            next_cycle();
        end
        vin[1] = 2'b00;

        // In-flight transfer discarded by a reset pulse on the 3-cycle instance.
        vin[2] = 2'b01;
        @(negedge clk);
        chk("flush_xfer_ready", rdy[2], 2'b01);
        next_cycle();
        vin[2] = 2'b11;
        rst[2] = 1'b1;
        @(negedge clk);
        chk("flush_rst_ready", rdy[2], 2'b00);
        chk("flush_rst_res_valid", rv[2], 2'b00);
        next_cycle();
        rst[2] = 1'b0;
        vin[2] = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("flush_res_valid", rv[2], 2'b00);
            next_cycle();
        end

        // Random traffic with occasional resets, checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            rnd_ops();
            for (int n = 0; n < 3; n++) begin
                vin[n] = 2'($urandom_range(0, 3));
                rst[n] = ($urandom_range(0, 63) == 0);
            end
            next_cycle();
        end
        for (int n = 0; n < 3; n++) begin
            rst[n] = 1'b0;
            vin[n] = 2'b00;
        end
        next_cycle();

`ifdef CMULT_ARB_STATS_EN
        // Counter saturation on requester 0.
        rst[0] = 1'b1;
        next_cycle();
        rst[0] = 1'b0;
        vin[0] = 2'b01;
        repeat (65540) next_cycle();
        vin[0] = 2'b00;
        @(negedge clk);
        chk("cnt0_sat", c0[0], 16'hFFFF);
        chk("cnt1_zero", c1[0], 16'h0000);
        next_cycle();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
